// File: rtl/serial_bus_arbiter_n.sv
// serial_bus_arbiter_n: round-robin arbiter that routes NM serial masters
// onto NS serial slaves, with select decode, error response and timeout.
module serial_bus_arbiter_n #(
  parameter int NM      = 2,
  parameter int NS      = 3,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  localparam int OWN_W  = $clog2(NM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_addr,
  input  logic [NM-1:0]    m_addr_valid,
  input  logic [NM-1:0]    m_data,
  input  logic [NM-1:0]    m_valid,
  input  logic [NM-1:0]    m_write_en,
  input  logic [NM-1:0]    m_burst,
  output logic [NM-1:0]    m_grant,
  output logic [NM-1:0]    m_ready,
  output logic [NM-1:0]    m_data_out,
  output logic [NM-1:0]    m_valid_out,
  output logic [NM-1:0]    m_error,
  output logic [NS-1:0]    s_address,
  output logic [NS-1:0]    s_data,
  output logic [NS-1:0]    s_valid,
  output logic [NS-1:0]    s_write_en,
  output logic [NS-1:0]    s_burst,
  output logic [NS-1:0]    s_bus_ready,
  input  logic [NS-1:0]    s_ready,
  input  logic [NS-1:0]    s_data_in,
  input  logic [NS-1:0]    s_valid_in,
  input  logic [NS-1:0]    s_hold,
  output logic [1:0]       state,
  output logic [OWN_W-1:0] owner
);

  localparam int CNT_W = $clog2(SEL_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ROUTE  = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

  state_e           state_q;
  logic [OWN_W-1:0] owner_q;
  logic [OWN_W-1:0] last_q;
  logic [OWN_W-1:0] pick_d;
  logic [NM-1:0]    grant_q;
  logic [NM-1:0]    error_q;
  logic [NM-1:0]    own_oh;
  logic [NM-1:0]    pick_oh;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] slv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TO_W-1:0]  to_q;
  logic [NS-1:0]    slv_oh;

  logic req_own;
  logic av_own;
  logic ad_own;
  logic dat_own;
  logic dv_own;
  logic we_own;
  logic bu_own;
  logic rdy_sel;
  logic din_sel;
  logic vin_sel;
  logic hold_sel;
  logic route;
  logic act;
  logic sel_last;
  logic sel_ok;
  logic to_hit;

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    pick_d  = last_q;
    pick_oh = '0;
    for (int i = 1; i <= NM; i++) begin
      idx = (int'(last_q) + i) % NM;
      for (int j = 0; j < NM; j++) begin
        if (!found && j == idx && m_req[j]) begin
          found      = 1'b1;
          pick_d     = OWN_W'(j);
          pick_oh[j] = 1'b1;
        end
      end
    end
  end

  // One-hot decodes of the registered owner and selected slave.
  always_comb begin
    own_oh = '0;
    slv_oh = '0;
    for (int j = 0; j < NM; j++) begin
      own_oh[j] = (j == int'(owner_q));
    end
    for (int j = 0; j < NS; j++) begin
      slv_oh[j] = (j == int'(slv_q));
    end
  end

  assign req_own  = |(m_req & own_oh);
  assign av_own   = |(m_addr_valid & own_oh);
  assign ad_own   = |(m_addr & own_oh);
  assign dat_own  = |(m_data & own_oh);
  assign dv_own   = |(m_valid & own_oh);
  assign we_own   = |(m_write_en & own_oh);
  assign bu_own   = |(m_burst & own_oh);
  assign rdy_sel  = |(s_ready & slv_oh);
  assign din_sel  = |(s_data_in & slv_oh);
  assign vin_sel  = |(s_valid_in & slv_oh);
  assign hold_sel = |(s_hold & slv_oh);

  assign route    = (state_q == S_ROUTE);
  assign act      = av_own | dv_own | vin_sel | hold_sel;
  assign sel_d    = SEL_W'({sel_q, ad_own});
  assign sel_last = (cnt_q == CNT_W'(SEL_W - 1));
  assign sel_ok   = (int'(sel_d) < NS);
  assign to_hit   = (to_q == TO_W'(TIMEOUT - 1));

  // Routing mux: only the owner and the selected slave see traffic.
  assign s_address   = route ? (slv_oh & {NS{ad_own & av_own}}) : '0;
  assign s_data      = route ? (slv_oh & {NS{dat_own}}) : '0;
  assign s_valid     = route ? (slv_oh & {NS{dv_own}}) : '0;
  assign s_write_en  = route ? (slv_oh & {NS{we_own}}) : '0;
  assign s_burst     = route ? (slv_oh & {NS{bu_own}}) : '0;
  assign s_bus_ready = route ? slv_oh : '0;
  assign m_ready     = route ? (own_oh & {NM{rdy_sel}}) : '0;
  assign m_data_out  = route ? (own_oh & {NM{din_sel}}) : '0;
  assign m_valid_out = route ? (own_oh & {NM{vin_sel}}) : '0;

  assign m_grant = grant_q;
  assign m_error = error_q;
  assign state   = state_q;
  assign owner   = owner_q;

  // Arbitration FSM: grant, select decode, route with timeout, error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= OWN_W'(NM - 1);
      grant_q <= '0;
      error_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      slv_q   <= '0;
      to_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|m_req) begin
            owner_q <= pick_d;
            last_q  <= pick_d;
            grant_q <= pick_oh;
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (!req_own) begin
            grant_q <= '0;
            state_q <= S_IDLE;
          end else if (av_own) begin
            sel_q <= sel_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (sel_last) begin
              if (sel_ok) begin
                slv_q   <= sel_d;
                to_q    <= '0;
                state_q <= S_ROUTE;
              end else begin
                grant_q <= '0;
                error_q <= own_oh;
                state_q <= S_ERROR;
              end
            end
          end
        end
        S_ROUTE: begin
          if (!req_own) begin
            grant_q <= '0;
            state_q <= S_IDLE;
          end else if (act) begin
            to_q <= '0;
          end else if (to_hit) begin
            to_q    <= '0;
            grant_q <= '0;
            error_q <= own_oh;
            state_q <= S_ERROR;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        S_ERROR: begin
          error_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter_n.sv
// tb_serial_bus_arbiter_n: table vectors, directed corner sequences
// and random traffic against a behavioural arbiter model.
module tb_serial_bus_arbiter_n;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SEL_W = 2;
  localparam int TIMEOUT = 8;
  localparam int TO_W = 4;

  logic clk;
  logic reset;
  logic [NM-1:0] m_req, m_addr, m_addr_valid, m_data;
  logic [NM-1:0] m_valid, m_write_en, m_burst;
  logic [NM-1:0] m_grant, m_ready, m_data_out, m_valid_out, m_error;
  logic [NS-1:0] s_address, s_data, s_valid, s_write_en, s_burst;
  logic [NS-1:0] s_bus_ready, s_ready, s_data_in, s_valid_in, s_hold;
  logic [1:0] state;
  logic [0:0] owner;

  int checks = 0;
  int errors = 0;

  serial_bus_arbiter_n #(
    .NM(NM), .NS(NS), .SEL_W(SEL_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_addr(m_addr),
    .m_addr_valid(m_addr_valid), .m_data(m_data),
    .m_valid(m_valid), .m_write_en(m_write_en),
    .m_burst(m_burst), .m_grant(m_grant),
    .m_ready(m_ready), .m_data_out(m_data_out),
    .m_valid_out(m_valid_out), .m_error(m_error),
    .s_address(s_address), .s_data(s_data),
    .s_valid(s_valid), .s_write_en(s_write_en),
    .s_burst(s_burst), .s_bus_ready(s_bus_ready),
    .s_ready(s_ready), .s_data_in(s_data_in),
    .s_valid_in(s_valid_in), .s_hold(s_hold),
    .state(state), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting select, 2 routing, 3 error.
  int ph, mo, ml, ms, idle;
  int selq[$];

  task automatic model_reset();
    ph = 0; mo = 0; ml = NM - 1; ms = 0; idle = 0;
    selq.delete();
  endtask

  task automatic model_edge();
    int v;
    bit a;
    case (ph)
      0: if (|m_req) begin
        for (int k = 1; k <= NM; k++) begin
          if (m_req[(ml + k) % NM]) begin
            mo = (ml + k) % NM;
            break;
          end
        end
        ml = mo;
        selq.delete();
        ph = 1;
      end
      1: if (!m_req[mo]) ph = 0;
      else if (m_addr_valid[mo]) begin
        selq.push_back(int'(m_addr[mo]));
        if (selq.size() == SEL_W) begin
          v = 0;
          foreach (selq[k]) v = v * 2 + selq[k];
          if (v < NS) begin
            ms = v; idle = 0; ph = 2;
          end else ph = 3;
        end
      end
      2: begin
        a = m_addr_valid[mo] | m_valid[mo] |
            s_valid_in[ms] | s_hold[ms];
        if (!m_req[mo]) ph = 0;
        else if (a) idle = 0;
        else begin
          idle++;
          if (idle == TIMEOUT) ph = 3;
        end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic check_all();
    logic [NM-1:0] eg, er, emr, emd, emv;
    logic [NS-1:0] esa, esd, esv, esw, esb, esr;
    eg = '0; er = '0; emr = '0; emd = '0; emv = '0;
    esa = '0; esd = '0; esv = '0; esw = '0; esb = '0; esr = '0;
    if (ph == 1 || ph == 2) eg[mo] = 1'b1;
    if (ph == 3) er[mo] = 1'b1;
    if (ph == 2) begin
      esa[ms] = m_addr[mo] & m_addr_valid[mo];
      esd[ms] = m_data[mo];
      esv[ms] = m_valid[mo];
      esw[ms] = m_write_en[mo];
      esb[ms] = m_burst[mo];
      esr[ms] = 1'b1;
      emr[mo] = s_ready[ms];
      emd[mo] = s_data_in[ms];
      emv[mo] = s_valid_in[ms];
    end
    cmp("m_grant", m_grant, eg);
    cmp("m_error", m_error, er);
    cmp("m_ready", m_ready, emr);
    cmp("m_data_out", m_data_out, emd);
    cmp("m_valid_out", m_valid_out, emv);
    cmp("s_address", s_address, esa);
    cmp("s_data", s_data, esd);
    cmp("s_valid", s_valid, esv);
    cmp("s_write_en", s_write_en, esw);
    cmp("s_burst", s_burst, esb);
    cmp("s_bus_ready", s_bus_ready, esr);
    cmp("state", state, ph);
    cmp("owner", owner, mo);
  endtask

  // Inputs are held from the falling edge; check, then cross one edge.
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    m_addr = '0; m_addr_valid = '0; m_data = '0; m_valid = '0;
    m_write_en = '0; m_burst = '0; s_ready = '0; s_data_in = '0;
    s_valid_in = '0; s_hold = '0;
  endtask

  // Grant master `who` from IDLE and shift in select value v.
  task automatic sel_bits(input int who, input int v);
    m_req = '0;
    m_req[who] = 1'b1;
    step();
    for (int b = SEL_W - 1; b >= 0; b--) begin
      m_addr_valid = '1;
      m_addr = {NM{v[b]}};
      step();
    end
    m_addr_valid = '0;
    m_addr = '0;
  endtask

  function automatic logic [NM-1:0] rnm(input int d);
    logic [NM-1:0] r;
    for (int j = 0; j < NM; j++) r[j] = ($urandom_range(0, 7) < d);
    return r;
  endfunction

  function automatic logic [NS-1:0] rns(input int d);
    logic [NS-1:0] r;
    for (int j = 0; j < NS; j++) r[j] = ($urandom_range(0, 7) < d);
    return r;
  endfunction

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] av;
    logic [1:0] addr;
    logic [2:0] svi;
    logic [2:0] sdi;
    logic [1:0] st;
    logic [1:0] gr;
    logic [2:0] sbr;
    logic [2:0] sadr;
    logic [1:0] mvo;
    logic [1:0] mdo;
  } vec_t;

  vec_t tv[11];
  int dens;

  initial begin
    tv[0]  = '{2'b11, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd0, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[1]  = '{2'b11, 2'b01, 2'b00, 3'b000, 3'b000,
               2'd1, 2'b01, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[2]  = '{2'b11, 2'b01, 2'b01, 3'b000, 3'b000,
               2'd1, 2'b01, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[3]  = '{2'b11, 2'b01, 2'b01, 3'b010, 3'b010,
               2'd2, 2'b01, 3'b010, 3'b010, 2'b01, 2'b01};
    tv[4]  = '{2'b11, 2'b01, 2'b00, 3'b010, 3'b000,
               2'd2, 2'b01, 3'b010, 3'b000, 2'b01, 2'b00};
    tv[5]  = '{2'b11, 2'b01, 2'b01, 3'b010, 3'b010,
               2'd2, 2'b01, 3'b010, 3'b010, 2'b01, 2'b01};
    tv[6]  = '{2'b10, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd2, 2'b01, 3'b010, 3'b000, 2'b00, 2'b00};
    tv[7]  = '{2'b11, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd0, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[8]  = '{2'b11, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd1, 2'b10, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[9]  = '{2'b01, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd1, 2'b10, 3'b000, 3'b000, 2'b00, 2'b00};
    tv[10] = '{2'b00, 2'b00, 2'b00, 3'b000, 3'b000,
               2'd0, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00};

    reset = 1'b0;
    m_req = '0;
    clr_in();
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    cmp("rst_state", state, 2'd0);
    cmp("rst_owner", owner, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Table: grant, select decode, routing, round robin.
    foreach (tv[i]) begin
      m_req = tv[i].req;
      m_addr_valid = tv[i].av;
      m_addr = tv[i].addr;
      s_valid_in = tv[i].svi;
      s_data_in = tv[i].sdi;
      #1;
      cmp("tbl_state", state, tv[i].st);
      cmp("tbl_grant", m_grant, tv[i].gr);
      cmp("tbl_sbr", s_bus_ready, tv[i].sbr);
      cmp("tbl_saddr", s_address, tv[i].sadr);
      cmp("tbl_mvo", m_valid_out, tv[i].mvo);
      cmp("tbl_mdo", m_data_out, tv[i].mdo);
      step();
    end
    clr_in();

    // Unmapped select -> one-cycle error.
    sel_bits(0, 3);
    #1;
    cmp("err_state", state, 2'd3);
    cmp("err_pulse", m_error, 2'b01);
    cmp("err_grant", m_grant, 2'b00);
    step();
    #1;
    cmp("err_end", m_error, 2'b00);
    cmp("err_idle", state, 2'd0);

    // Inactivity timeout.
    sel_bits(1, 0);
    for (int k = 0; k < TIMEOUT; k++) step();
    #1;
    cmp("to_state", state, 2'd3);
    cmp("to_pulse", m_error, 2'b10);
    step();

    // Hold suspends the timeout.
    sel_bits(0, 2);
    s_hold = 3'b100;
    for (int k = 0; k < 20; k++) step();
    #1;
    cmp("hold_route", state, 2'd2);
    s_hold = '0;
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    #1;
    cmp("hold_pre", state, 2'd2);
    step();
    #1;
    cmp("hold_to", state, 2'd3);
    step();

    // Asynchronous reset mid-route.
    sel_bits(0, 1);
    s_valid_in = '1;
    #2;
    cmp("pre_rst_sbr", s_bus_ready, 3'b010);
    reset = 1'b0;
    #1;
    cmp("arst_sbr", s_bus_ready, 3'b000);
    cmp("arst_mvo", m_valid_out, 2'b00);
    cmp("arst_grant", m_grant, 2'b00);
    cmp("arst_state", state, 2'd0);
    model_reset();
    check_all();
    s_valid_in = '0;
    @(negedge clk);
    reset = 1'b1;
    m_req = 2'b10;
    step();
    m_req = 2'b11;
    step();
    #1;
    cmp("rr_own1", owner, 1'b1);
    cmp("rr_gnt1", m_grant, 2'b10);
    m_req = 2'b01;
    step();
    step();
    #1;
    cmp("rr_own0", owner, 1'b0);
    cmp("rr_gnt0", m_grant, 2'b01);

    // Release after one select bit.
    m_addr_valid = 2'b01;
    m_addr = 2'b01;
    step();
    clr_in();
    m_req = '0;
    step();
    #1;
    cmp("abort_state", state, 2'd0);
    cmp("abort_grant", m_grant, 2'b00);

    // Random traffic with bursty activity density.
    dens = 4;
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) dens = $urandom_range(0, 4);
      for (int j = 0; j < NM; j++) begin
        if ($urandom_range(0, 9) == 0) m_req[j] = ~m_req[j];
      end
      m_addr_valid = rnm(dens);
      m_valid = rnm(dens);
      m_addr = NM'($urandom);
      m_data = NM'($urandom);
      m_write_en = NM'($urandom);
      m_burst = NM'($urandom);
      s_ready = NS'($urandom);
      s_data_in = NS'($urandom);
      s_valid_in = rns(dens);
      s_hold = rns(dens / 2);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bus_arbiter_n.md
Name: serial_bus_arbiter_n

Overview:
Parametrised successor to the fixed two-master/three-slave serial bus arbiter. It arbitrates NM serial masters onto NS serial slaves with round-robin fairness. It decodes the slave select from the leading serial address bits and routes the one-bit address, data and handshake lines between the owning master and the selected slave. It adds an error response for unmapped selects and an inactivity timeout; slave hold suspends the timeout.

Parameters:
NM, 2, number of masters (>=2)
NS, 3, number of slaves (>=1, NS <= 2**SEL_W)
SEL_W, 2, slave-select bits at head of each serial address
TIMEOUT, 255, idle ROUTE cycles before forced error (>=1)
TO_W, 8, timeout counter width (2**TO_W > TIMEOUT)
OWN_W, $clog2(NM), owner index width (derived; not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
m_req  in  NM  per-master bus request
m_addr  in  NM  per-master serial address bit
m_addr_valid  in  NM  qualifies m_addr
m_data  in  NM  per-master serial write data bit
m_valid  in  NM  qualifies m_data
m_write_en  in  NM  1 = write, 0 = read
m_burst  in  NM  burst request
m_grant  out  NM  bus available to master (registered)
m_ready  out  NM  selected slave ready, routed to owner
m_data_out  out  NM  slave read-data bit, routed to owner
m_valid_out  out  NM  qualifies m_data_out
m_error  out  NM  one-cycle error pulse to owner
s_address  out  NS  serial address bit to slave (select bits stripped)
s_data  out  NS  serial data bit to slave
s_valid  out  NS  qualifies s_data
s_write_en  out  NS  write enable to slave
s_burst  out  NS  burst to slave
s_bus_ready  out  NS  slave selected/bus owned
s_ready  in  NS  slave ready
s_data_in  in  NS  slave read-data bit
s_valid_in  in  NS  qualifies s_data_in
s_hold  in  NS  slave busy/split hold
state  out  2  FSM state: IDLE=0, SELECT=1, ROUTE=2, ERROR=3
owner  out  OWN_W  current/last granted master index

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; owner=0; internal last_owner=NM-1 so master 0 has top priority; sel shift reg=0; timeout counter=0.
- IDLE: outputs all 0. If any m_req, pick first requester scanning last_owner+1, last_owner+2, ... mod NM (wrap). At that edge: owner=pick, last_owner=pick, m_grant[pick]=1, sel=0, bit count=0, go SELECT. Grant latency is 1 edge after m_req is seen.
- SELECT: each cycle with m_addr_valid[owner]=1 shifts m_addr[owner] into sel, MSB first. These bits are never forwarded to any slave.
  - On the SEL_W-th bit's edge: if sel < NS, latch slv=sel and go ROUTE; else go ERROR.
  - m_req[owner]=0 in SELECT: m_grant cleared, go IDLE, no slave touched.
- ROUTE (combinational muxing from registered owner/slv):
  - s_address[slv]=m_addr[owner] gated by m_addr_valid[owner]; s_data[slv]=m_data[owner]; s_valid[slv]=m_valid[owner]; s_write_en[slv]=m_write_en[owner]; s_burst[slv]=m_burst[owner]; s_bus_ready[slv]=1.
  - m_ready[owner]=s_ready[slv]; m_data_out[owner]=s_data_in[slv]; m_valid_out[owner]=s_valid_in[slv].
  - All non-selected slave and non-owner master outputs are 0.
  - Timeout counter: clears on any cycle with m_addr_valid, m_valid, s_valid_in or s_hold high. Otherwise it increments; when it reaches TIMEOUT, go ERROR.
  - m_req[owner]=0: m_grant cleared, go IDLE at that edge. This has priority over a timeout in the same cycle.
- ERROR (1 cycle): m_grant=0, m_error[owner]=1, all slave outputs 0; then IDLE. last_owner is kept, so the next owner rotates.
- No preemption: a higher-index or lower-index request never interrupts an owner.
- Simultaneous release and new request: IDLE is visited for 1 cycle, so back-to-back grants are separated by one idle cycle.
- Reset mid-transaction: immediate return to reset values. The slave sees s_bus_ready fall asynchronously.

Test Plan:
1. After reset, m_req=2'b11 -> m_grant=2'b01 one edge later, owner=0. Master 0 drops req -> 1 IDLE cycle -> m_grant=2'b10 (round robin).
2. Master 0 sends select bits 0,1 then address bits 1,0,1 -> state=ROUTE, s_bus_ready=3'b010, s_address[1] sequence 1,0,1, slaves 0 and 2 all outputs 0. Slave 1 s_valid_in/s_data_in are visible on m_valid_out[0]/m_data_out[0] in the same cycle.
3. Select bits 1,1 with NS=3 -> ERROR for 1 cycle, m_error[owner]=1 for exactly 1 cycle, m_grant drops, no s_* output ever high.
4. TIMEOUT=8, ROUTE with no activity -> ERROR on the 8th idle cycle. Repeat with s_hold[slv]=1 held for 20 cycles -> no error; drop hold -> error 8 cycles later.
5. Assert reset low mid-ROUTE -> all outputs 0 without a clock edge. After release, m_req=2'b10 then 2'b11 -> master 1 granted first (only requester), next grant goes to master 0.
6. Master drops m_req after 1 select bit -> IDLE next edge, m_grant=0, no slave s_bus_ready pulse.
